// File: rtl/ddr3_rd_capture.sv
// ddr3_rd_capture
//   Read-data capture stage behind the per-lane DDR IOBs. Each accepted BL8
//   read command travels through a fixed-latency pipe. Its capture window
//   then collects 4 PCLK cycles x 2 beats into one wide burst word. The
//   word is queued in a small FIFO for the consumer. The DRAM side cannot
//   be stalled, so flow control is done with credits (rd_ready_o).
//
// Parameters
//   WIDTH       DQ lanes
//   RD_LAT      PCLK cycles from accepted rd_cmd_i to first beat pair (>= 2)
//   FIFO_ABITS  log2 of FIFO depth in bursts
//
// Ports
//   PCLK         fabric clock
//   RESET        synchronous, active-high reset
//   lat_trim_i   extra latency 0..7 (only with DDR3_RDCAP_TRIM_EN)
//   rd_cmd_i     one BL8 read issued this cycle
//   rd_ready_o   credit available (FIFO count + in-flight bursts < depth)
//   dq_q0_i      even beat per lane
//   dq_q1_i      odd beat per lane
//   m_valid_o    burst word available
//   m_ready_i    consumer accepts word when m_valid_o && m_ready_i
//   m_data_o     burst word, beat b at [b*WIDTH +: WIDTH]
//   busy_o       a burst is in the latency pipe or capture window
//   overflow_o   sticky: a burst was dropped on a full FIFO
//   proto_err_o  sticky: rd_cmd_i arrived less than 4 cycles after the last one
//
// Configuration macro
//   DDR3_RDCAP_TRIM_EN  adds lat_trim_i; latency = RD_LAT + trim. The trim
//                       value is captured only while idle.

module ddr3_rd_capture #(
    parameter int WIDTH      = 16,
    parameter int RD_LAT     = 8,
    parameter int FIFO_ABITS = 2
) (
    input  logic                 PCLK,
    input  logic                 RESET,
`ifdef DDR3_RDCAP_TRIM_EN
    input  logic [2:0]           lat_trim_i,
`endif
    input  logic                 rd_cmd_i,
    output logic                 rd_ready_o,
    input  logic [WIDTH-1:0]     dq_q0_i,
    input  logic [WIDTH-1:0]     dq_q1_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [8*WIDTH-1:0]   m_data_o,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic                 proto_err_o
);

    localparam int DEPTH = 1 << FIFO_ABITS;
`ifdef DDR3_RDCAP_TRIM_EN
    localparam int PIPE_LEN = RD_LAT + 7;
`else
    localparam int PIPE_LEN = RD_LAT;
`endif
    localparam logic [FIFO_ABITS:0] DEPTH_C = (FIFO_ABITS+1)'(DEPTH);

    logic [PIPE_LEN-1:0]   pipe_q, pipe_d;
    logic [1:0]            gap_q, gap_d;
    logic                  win_q, win_d;
    logic [1:0]            beat_q, beat_d;
    logic                  wr_pend_q, wr_pend_d;
    logic [8*WIDTH-1:0]    asm_q, asm_d;
    logic [8*WIDTH-1:0]    mem_q [DEPTH];
    logic [8*WIDTH-1:0]    mem_d [DEPTH];
    logic [FIFO_ABITS-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_ABITS:0]   count_q, count_d;
    logic [7:0]            infl_q, infl_d;
    logic                  ready_q, ready_d;
    logic                  ovf_q, ovf_d;
    logic                  perr_q, perr_d;
`ifdef DDR3_RDCAP_TRIM_EN
    logic [2:0]            trim_q, trim_d;
`endif

    logic       accept, start, cap_en, pop, push, drop;
    logic [1:0] cap_idx;
    logic [8:0] credit_sum;

    assign busy_o      = (|pipe_q) || win_q;
    assign m_valid_o   = (count_q != '0);
    assign m_data_o    = mem_q[rptr_q];
    assign rd_ready_o  = ready_q;
    assign overflow_o  = ovf_q;
    assign proto_err_o = perr_q;

    always_comb begin
        pipe_d    = pipe_q >> 1;
        gap_d     = gap_q;
        win_d     = win_q;
        beat_d    = beat_q;
        asm_d     = asm_q;
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        infl_d    = infl_q;
        ovf_d     = ovf_q;
        perr_d    = perr_q;
`ifdef DDR3_RDCAP_TRIM_EN
        trim_d    = busy_o ? trim_q : lat_trim_i;
`endif

        // spacing down-counter: zero means a new command may be accepted
        accept = rd_cmd_i && (gap_q == 2'd0);
        if (accept)
            gap_d = 2'd3;
        else if (gap_q != 2'd0)
            gap_d = gap_q - 2'd1;
        if (rd_cmd_i && !accept)
            perr_d = 1'b1;

        // commands enter the pipe at the tap matching their latency and
        // shift toward bit 0, which marks the first capture cycle
`ifdef DDR3_RDCAP_TRIM_EN
        for (int i = 0; i < 8; i++) begin
            if (accept && (trim_q == 3'(i)))
                pipe_d[RD_LAT-1+i] = 1'b1;
        end
`else
        if (accept)
            pipe_d[RD_LAT-1] = 1'b1;
`endif

        start   = pipe_q[0];
        cap_en  = start || win_q;
        cap_idx = start ? 2'd0 : beat_q;
        for (int k = 0; k < 4; k++) begin
            if (cap_en && (cap_idx == 2'(k))) begin
                asm_d[(2*k)*WIDTH   +: WIDTH] = dq_q0_i;
                asm_d[(2*k+1)*WIDTH +: WIDTH] = dq_q1_i;
            end
        end

        // command spacing guarantees a new window never starts while one is open
        if (start) begin
            win_d  = 1'b1;
            beat_d = 2'd1;
        end else if (win_q) begin
            if (beat_q == 2'd3) begin
                win_d  = 1'b0;
                beat_d = 2'd0;
            end else begin
                beat_d = beat_q + 2'd1;
            end
        end
        wr_pend_d = win_q && (beat_q == 2'd3);

        // a pop on the same edge frees the slot for an otherwise-full write
        pop  = (count_q != '0) && m_ready_i;
        push = wr_pend_q && ((count_q != DEPTH_C) || pop);
        drop = wr_pend_q && (count_q == DEPTH_C) && !pop;

        if (push) begin
            mem_d[wptr_q] = asm_q;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop)
            rptr_d = rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop)
            ovf_d = 1'b1;

        infl_d     = infl_q + {7'd0, accept} - {7'd0, wr_pend_q};
        credit_sum = 9'(count_d) + 9'(infl_d);
        ready_d    = credit_sum < 9'(DEPTH);
    end

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            pipe_q    <= '0;
            gap_q     <= '0;
            win_q     <= 1'b0;
            beat_q    <= '0;
            wr_pend_q <= 1'b0;
            asm_q     <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            infl_q    <= '0;
            ready_q   <= 1'b0;
            ovf_q     <= 1'b0;
            perr_q    <= 1'b0;
`ifdef DDR3_RDCAP_TRIM_EN
            trim_q    <= '0;
`endif
        end else begin
            pipe_q    <= pipe_d;
            gap_q     <= gap_d;
            win_q     <= win_d;
            beat_q    <= beat_d;
            wr_pend_q <= wr_pend_d;
            asm_q     <= asm_d;
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            infl_q    <= infl_d;
            ready_q   <= ready_d;
            ovf_q     <= ovf_d;
            perr_q    <= perr_d;
`ifdef DDR3_RDCAP_TRIM_EN
            trim_q    <= trim_d;
`endif
        end
    end

endmodule

// File: tb/tb_ddr3_rd_capture.sv
module tb_ddr3_rd_capture;

    localparam int W = 16;
    localparam int L = 8;
    localparam int D = 4;

    logic           PCLK = 1'b0;
    logic           RESET = 1'b1;
    logic           rd_cmd_i = 1'b0;
    logic           m_ready_i = 1'b0;
    logic [W-1:0]   dq_q0_i = '0;
    logic [W-1:0]   dq_q1_i = '0;
    logic           rd_ready_o, m_valid_o, busy_o, overflow_o, proto_err_o;
    logic [8*W-1:0] m_data_o;

    ddr3_rd_capture #(.WIDTH(W), .RD_LAT(L), .FIFO_ABITS(2)) dut (
        .PCLK        (PCLK),
        .RESET       (RESET),
        .rd_cmd_i    (rd_cmd_i),
        .rd_ready_o  (rd_ready_o),
        .dq_q0_i     (dq_q0_i),
        .dq_q1_i     (dq_q1_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .busy_o      (busy_o),
        .overflow_o  (overflow_o),
        .proto_err_o (proto_err_o)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    // reference model: history of driven beats, issue edges of bursts
    // not yet written, and the FIFO content as a queue of words
    logic [W-1:0]   h0 [0:8191];
    logic [W-1:0]   h1 [0:8191];
    int             inf_q[$];
    logic [8*W-1:0] mq[$];
    int             last_acc = 0;
    bit             have_last = 0;
    bit             ovf_m = 0, perr_m = 0, rdy_m = 0;

    task automatic chk(input string tag, input logic [8*W-1:0] obs, input logic [8*W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    function automatic logic [8*W-1:0] word_of(input int n);
        logic [8*W-1:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            w[(2*k)*W   +: W] = h0[n+L+k];
            w[(2*k+1)*W +: W] = h1[n+L+k];
        end
        return w;
    endfunction

    task automatic model_edge();
        if (RESET) begin
            inf_q.delete();
            mq.delete();
            have_last = 0;
            ovf_m = 0;
            perr_m = 0;
            rdy_m = 0;
            return;
        end
        h0[edge_n] = dq_q0_i;
        h1[edge_n] = dq_q1_i;
        if (mq.size() > 0 && m_ready_i)
            void'(mq.pop_front());
        if (inf_q.size() > 0 && inf_q[0] + L + 4 == edge_n) begin
            if (mq.size() < D)
                mq.push_back(word_of(inf_q[0]));
            else
                ovf_m = 1;
            void'(inf_q.pop_front());
        end
        if (rd_cmd_i) begin
            if (!have_last || edge_n - last_acc >= 4) begin
                inf_q.push_back(edge_n);
                last_acc = edge_n;
                have_last = 1;
            end else begin
                perr_m = 1;
            end
        end
        rdy_m = (mq.size() + inf_q.size()) < D;
    endtask

    task automatic check_all();
        bit busy_m;
        busy_m = 0;
        foreach (inf_q[i])
            if (edge_n - inf_q[i] <= L + 2)
                busy_m = 1;
        chk("m_valid", m_valid_o, mq.size() != 0);
        if (mq.size() != 0)
            chk("m_data", m_data_o, mq[0]);
        chk("rd_ready", rd_ready_o, rdy_m);
        chk("busy", busy_o, busy_m);
        chk("overflow", overflow_o, ovf_m);
        chk("proto_err", proto_err_o, perr_m);
    endtask

    task automatic cyc(input bit cmd, input bit rdy, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit rst);
        rd_cmd_i  = cmd;
        m_ready_i = rdy;
        dq_q0_i   = a;
        dq_q1_i   = b;
        RESET     = rst;
        @(posedge PCLK);
        model_edge();
        #1;
        check_all();
        edge_n++;
    endtask

    task automatic cyc_r(input bit cmd, input bit rdy);
        cyc(cmd, rdy, W'($urandom), W'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        // reset state
        do_reset();
        chk("reset_valid", m_valid_o, 1'b0);
        chk("reset_ready", rd_ready_o, 1'b0);
        cyc_r(1'b0, 1'b0);
        chk("post_reset_ready", rd_ready_o, 1'b1);

        // single burst with a recognisable beat pattern
        cyc_r(1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            if (i >= L && i <= L + 3)
                cyc(1'b0, 1'b0, 16'h0A00 + 16'(i - L), 16'h0B00 + 16'(i - L), 1'b0);
            else
                cyc_r(1'b0, 1'b0);
            if (i == 11)
                chk("t1_valid_early", m_valid_o, 1'b0);
        end
        chk("t1_valid", m_valid_o, 1'b1);
        chk("t1_data", m_data_o, 128'h0B03_0A03_0B02_0A02_0B01_0A01_0B00_0A00);
        for (int i = 0; i < 4; i++) cyc_r(1'b0, 1'b1);

        // four back-to-back commands, consumer always ready
        for (int c = 0; c < 4; c++) begin
            cyc_r(1'b1, 1'b1);
            for (int i = 0; i < 3; i++) cyc_r(1'b0, 1'b1);
        end
        for (int i = 0; i < 16; i++) cyc_r(1'b0, 1'b1);
        chk("t2_proto", proto_err_o, 1'b0);

        // second command too early
        cyc_r(1'b1, 1'b1);
        cyc_r(1'b0, 1'b1);
        cyc_r(1'b0, 1'b1);
        cyc_r(1'b1, 1'b1);
        chk("t3_proto", proto_err_o, 1'b1);
        for (int i = 0; i < 16; i++) cyc_r(1'b0, 1'b1);

        // five commands with the consumer stalled -> overflow on the fifth
        do_reset();
        for (int c = 0; c < 5; c++) begin
            cyc_r(1'b1, 1'b0);
            if (c == 3) chk("t4_ready_low", rd_ready_o, 1'b0);
            for (int i = 0; i < 3; i++) cyc_r(1'b0, 1'b0);
        end
        for (int i = 0; i < 14; i++) cyc_r(1'b0, 1'b0);
        chk("t4_overflow", overflow_o, 1'b1);
        for (int i = 0; i < 8; i++) cyc_r(1'b0, 1'b1);
        chk("t4_drained", m_valid_o, 1'b0);

        // reset in the middle of a capture window
        do_reset();
        cyc_r(1'b0, 1'b1);
        cyc_r(1'b1, 1'b1);
        for (int i = 0; i < 9; i++) cyc_r(1'b0, 1'b1);
        cyc(1'b0, 1'b1, '0, '0, 1'b1);
        for (int i = 0; i < 20; i++) cyc_r(1'b0, 1'b1);
        chk("t5_busy", busy_o, 1'b0);
        chk("t5_ready", rd_ready_o, 1'b1);
        chk("t5_valid", m_valid_o, 1'b0);

        // random traffic
        do_reset();
        for (int i = 0; i < 800; i++)
            cyc_r($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6);
        for (int i = 0; i < 30; i++) cyc_r(1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
